// File: rtl/arm_regfile_if.sv
// Request/response bundle between the execution units (master) and the
// banked register file (slave).
interface arm_regfile_if;
    logic        read_en;
    logic [3:0]  read_reg;
    logic [31:0] read_value;
    logic        write_en;
    logic [3:0]  write_reg;
    logic [31:0] write_value;
    logic        write_restore_from_SPSR;
    logic        pc_inc;
    logic        cpsr_we;
    logic [31:0] cpsr_wdata;
    logic        spsr_we;
    logic [31:0] spsr_wdata;
    logic [31:0] cpsr;
    logic [31:0] pc;
    logic        spsr_err;

    modport master (
        output read_en, read_reg, write_en, write_reg, write_value,
               write_restore_from_SPSR, pc_inc, cpsr_we, cpsr_wdata,
               spsr_we, spsr_wdata,
        input  read_value, cpsr, pc, spsr_err
    );

    modport slave (
        input  read_en, read_reg, write_en, write_reg, write_value,
               write_restore_from_SPSR, pc_inc, cpsr_we, cpsr_wdata,
               spsr_we, spsr_wdata,
        output read_value, cpsr, pc, spsr_err
    );
endinterface

// File: rtl/arm_regfile.sv
// Banked ARM7 register file: r0-r15, per-mode r13/r14 and SPSR, CPSR.
// Optional macro BANKED_FIQ_EN: FIQ mode additionally banks r8-r12.
module arm_regfile #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
    input logic          clk,
    input logic          rst,
    arm_regfile_if.slave bus
);
    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } mode_e;

    // r_q[13]/r_q[14] are the user-bank copies; exception banks live apart.
    logic [31:0] r_q        [0:15];
    logic [31:0] r_d        [0:15];
    logic [31:0] r13_bank_q [0:4];
    logic [31:0] r13_bank_d [0:4];
    logic [31:0] r14_bank_q [0:4];
    logic [31:0] r14_bank_d [0:4];
    logic [31:0] spsr_q     [0:4];
    logic [31:0] spsr_d     [0:4];
    logic [31:0] cpsr_q, cpsr_d;
    logic [31:0] read_value_q, read_value_d;
    logic        spsr_err_q, spsr_err_d;
    logic [2:0]  bank_idx;
    logic        has_spsr;
    logic [31:0] rd_data;
`ifdef BANKED_FIQ_EN
    logic [31:0] fiq_r_q [8:12];
    logic [31:0] fiq_r_d [8:12];
    logic        is_fiq;
    logic        rd_fiq_hi, wr_fiq_hi;

    assign is_fiq    = (cpsr_q[4:0] == MODE_FIQ);
    assign rd_fiq_hi = is_fiq && (bus.read_reg >= 4'd8) && (bus.read_reg <= 4'd12);
    assign wr_fiq_hi = is_fiq && (bus.write_reg >= 4'd8) && (bus.write_reg <= 4'd12);
`endif

    always_comb begin
        has_spsr = 1'b1;
        bank_idx = 3'd0;
        case (cpsr_q[4:0])
            MODE_FIQ: bank_idx = 3'd0;
            MODE_IRQ: bank_idx = 3'd1;
            MODE_SVC: bank_idx = 3'd2;
            MODE_ABT: bank_idx = 3'd3;
            MODE_UND: bank_idx = 3'd4;
            default:  has_spsr = 1'b0;
        endcase
    end

    always_comb begin
        rd_data = r_q[bus.read_reg];
        if (has_spsr && bus.read_reg == 4'd13) rd_data = r13_bank_q[bank_idx];
        if (has_spsr && bus.read_reg == 4'd14) rd_data = r14_bank_q[bank_idx];
`ifdef BANKED_FIQ_EN
        if (rd_fiq_hi) rd_data = fiq_r_q[bus.read_reg];
`endif
    end

    always_comb begin
        r_d          = r_q;
        r13_bank_d   = r13_bank_q;
        r14_bank_d   = r14_bank_q;
        spsr_d       = spsr_q;
        cpsr_d       = cpsr_q;
        read_value_d = read_value_q;
        spsr_err_d   = 1'b0;
`ifdef BANKED_FIQ_EN
        fiq_r_d      = fiq_r_q;
`endif
        if (bus.read_en) read_value_d = rd_data;

        // pc_inc first so an explicit r15 write overrides it
        if (bus.pc_inc) r_d[15] = r_q[15] + 32'd4;

        if (bus.write_en) begin
            if (has_spsr && bus.write_reg == 4'd13)
                r13_bank_d[bank_idx] = bus.write_value;
            else if (has_spsr && bus.write_reg == 4'd14)
                r14_bank_d[bank_idx] = bus.write_value;
`ifdef BANKED_FIQ_EN
            else if (wr_fiq_hi)
                fiq_r_d[bus.write_reg] = bus.write_value;
`endif
            else
                r_d[bus.write_reg] = bus.write_value;
        end

        if (bus.cpsr_we) cpsr_d = bus.cpsr_wdata;
        if (bus.write_en && bus.write_restore_from_SPSR) begin
            if (has_spsr) cpsr_d = spsr_q[bank_idx];
            else          spsr_err_d = 1'b1;
        end

        // restore above reads spsr_q, so a same-edge SPSR write lands afterwards
        if (bus.spsr_we) begin
            if (has_spsr) spsr_d[bank_idx] = bus.spsr_wdata;
            else          spsr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) r_q[i] <= '0;
            r_q[15] <= RESET_PC;
            for (int unsigned i = 0; i < 5; i++) begin
                r13_bank_q[i] <= '0;
                r14_bank_q[i] <= '0;
                spsr_q[i]     <= '0;
            end
`ifdef BANKED_FIQ_EN
            for (int unsigned i = 8; i < 13; i++) fiq_r_q[i] <= '0;
`endif
            cpsr_q       <= RESET_CPSR;
            read_value_q <= '0;
            spsr_err_q   <= 1'b0;
        end else begin
            r_q          <= r_d;
            r13_bank_q   <= r13_bank_d;
            r14_bank_q   <= r14_bank_d;
            spsr_q       <= spsr_d;
`ifdef BANKED_FIQ_EN
            fiq_r_q      <= fiq_r_d;
`endif
            cpsr_q       <= cpsr_d;
            read_value_q <= read_value_d;
            spsr_err_q   <= spsr_err_d;
        end
    end

    assign bus.read_value = read_value_q;
    assign bus.cpsr       = cpsr_q;
    assign bus.pc         = r_q[15];
    assign bus.spsr_err   = spsr_err_q;
endmodule

// File: tb/tb_arm_regfile.sv
// Directed self-checking bench for arm_regfile using an expected-value queue.
module tb_arm_regfile;
    logic clk = 1'b0;
    logic rst = 1'b1;
    arm_regfile_if bus ();

    arm_regfile #(
        .RESET_PC   (32'h0000_0000),
        .RESET_CPSR (32'h0000_00D3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    string       tag_q [$];
    logic [31:0] val_q [$];

`ifdef BANKED_FIQ_EN
    localparam bit FIQ_BANKED = 1'b1;
`else
    localparam bit FIQ_BANKED = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_cmp++;
        if (val_q.size() == 0) begin
            n_mis++;
            $error("FAIL sb_empty: observed %h with no expected value queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                n_mis++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic do_write(input logic [3:0] r, input logic [31:0] v);
        bus.write_en = 1'b1; bus.write_reg = r; bus.write_value = v;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [3:0] r, input logic [31:0] exp_v);
        bus.read_en = 1'b1; bus.read_reg = r;
        expect_val(tag, exp_v);
        tick();
        bus.read_en = 1'b0;
        check(bus.read_value);
    endtask

    task automatic cpsr_write(input logic [31:0] v);
        bus.cpsr_we = 1'b1; bus.cpsr_wdata = v;
        tick();
        bus.cpsr_we = 1'b0;
    endtask

    task automatic spsr_write(input logic [31:0] v);
        bus.spsr_we = 1'b1; bus.spsr_wdata = v;
        tick();
        bus.spsr_we = 1'b0;
    endtask

    initial begin
        bus.read_en = 1'b0; bus.read_reg = '0;
        bus.write_en = 1'b0; bus.write_reg = '0; bus.write_value = '0;
        bus.write_restore_from_SPSR = 1'b0; bus.pc_inc = 1'b0;
        bus.cpsr_we = 1'b0; bus.cpsr_wdata = '0;
        bus.spsr_we = 1'b0; bus.spsr_wdata = '0;
        tick(); tick();
        rst = 1'b0;
        expect_val("reset_pc", 32'h0); check(bus.pc);
        expect_val("reset_cpsr", 32'hD3); check(bus.cpsr);

        // Read latency and hold
        do_write(4'd3, 32'hDEAD_BEEF);
        do_read("rd_r3", 4'd3, 32'hDEAD_BEEF);
        tick(); tick();
        expect_val("rd_hold", 32'hDEAD_BEEF); check(bus.read_value);

        // Mid-cycle asynchronous reset
        bus.pc_inc = 1'b1; tick(); tick(); tick(); bus.pc_inc = 1'b0;
        cpsr_write(32'h10);
        #2 rst = 1'b1;
        #1;
        expect_val("arst_pc", 32'h0);  check(bus.pc);
        expect_val("arst_cpsr", 32'hD3); check(bus.cpsr);
        expect_val("arst_rv", 32'h0);  check(bus.read_value);
        tick();
        rst = 1'b0;
        do_read("arst_r3", 4'd3, 32'h0);

        // Branch-with-link
        do_write(4'd15, 32'h100);
        do_read("bl_rd_pc", 4'd15, 32'h100);
        do_write(4'd14, 32'h104);
        do_write(4'd15, 32'h148);
        expect_val("bl_pc", 32'h148); check(bus.pc);
        do_read("bl_svc_r14", 4'd14, 32'h104);

        // Banking of r13/r14
        do_write(4'd13, 32'h1000);
        cpsr_write(32'h10);
        expect_val("usr_cpsr", 32'h10); check(bus.cpsr);
        do_read("usr_r13", 4'd13, 32'h0);
        do_read("usr_r14", 4'd14, 32'h0);
        cpsr_write(32'hD3);
        do_read("svc_r13", 4'd13, 32'h1000);

        // Restore from SPSR in IRQ, beating a same-edge cpsr_we
        cpsr_write(32'hD2);
        spsr_write(32'h10);
        expect_val("irq_spsr_err", 32'h0); check({31'b0, bus.spsr_err});
        bus.write_restore_from_SPSR = 1'b1; bus.cpsr_we = 1'b1; bus.cpsr_wdata = 32'hDF;
        do_write(4'd15, 32'h200);
        bus.write_restore_from_SPSR = 1'b0; bus.cpsr_we = 1'b0;
        expect_val("rst_pc", 32'h200); check(bus.pc);
        expect_val("rst_cpsr", 32'h10); check(bus.cpsr);
        expect_val("rst_err0", 32'h0); check({31'b0, bus.spsr_err});

        // Restore attempted in USR
        bus.write_restore_from_SPSR = 1'b1;
        do_write(4'd15, 32'h300);
        bus.write_restore_from_SPSR = 1'b0;
        expect_val("usr_rst_pc", 32'h300); check(bus.pc);
        expect_val("usr_rst_cpsr", 32'h10); check(bus.cpsr);
        expect_val("usr_err_pulse", 32'h1); check({31'b0, bus.spsr_err});
        tick();
        expect_val("usr_err_clear", 32'h0); check({31'b0, bus.spsr_err});
        spsr_write(32'h1F);
        expect_val("usr_spsrwe_err", 32'h1); check({31'b0, bus.spsr_err});
        tick();
        expect_val("usr_spsrwe_clr", 32'h0); check({31'b0, bus.spsr_err});

        // Restore writes the pre-restore bank; same-edge SPSR write lands after
        cpsr_write(32'hD1);
        spsr_write(32'hD3);
        bus.write_restore_from_SPSR = 1'b1; bus.spsr_we = 1'b1; bus.spsr_wdata = 32'hD2;
        do_write(4'd13, 32'hAAAA);
        bus.write_restore_from_SPSR = 1'b0; bus.spsr_we = 1'b0;
        expect_val("fiq_rst_cpsr", 32'hD3); check(bus.cpsr);
        do_read("svc_r13_kept", 4'd13, 32'h1000);
        cpsr_write(32'hD1);
        do_read("fiq_r13", 4'd13, 32'hAAAA);
        bus.write_restore_from_SPSR = 1'b1;
        do_write(4'd0, 32'h5);
        bus.write_restore_from_SPSR = 1'b0;
        expect_val("fiq_new_spsr", 32'hD2); check(bus.cpsr);
        do_read("irq_r0", 4'd0, 32'h5);

        // r8 sharing or FIQ banking
        do_write(4'd8, 32'h8888);
        cpsr_write(32'hD1);
        do_read("fiq_r8", 4'd8, FIQ_BANKED ? 32'h0 : 32'h8888);
        do_write(4'd8, 32'h1234);
        cpsr_write(32'hD3);
        do_read("svc_r8", 4'd8, FIQ_BANKED ? 32'h8888 : 32'h1234);

        // r15 write beats pc_inc; pc_inc wraps
        bus.pc_inc = 1'b1;
        do_write(4'd15, 32'h80);
        expect_val("coll_pc", 32'h80); check(bus.pc);
        tick();
        bus.pc_inc = 1'b0;
        expect_val("inc_pc", 32'h84); check(bus.pc);
        do_write(4'd15, 32'hFFFF_FFFC);
        bus.pc_inc = 1'b1; tick(); bus.pc_inc = 1'b0;
        expect_val("wrap_pc", 32'h0); check(bus.pc);

        n_cmp++;
        if (val_q.size() != 0) begin
            n_mis++;
            $error("FAIL sb_leftover: observed %0d entries expected 0", val_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/arm_regfile.md
Name: arm_regfile

Overview:
- Banked ARM7 register file. Services register read/write requests from the execution units (branch, ALU, load/store), which act as initiators.
- Holds r0-r15, the banked r13/r14 per exception mode, CPSR and one SPSR per exception mode.
- Implements the read-latency and write-commit contract the execution units rely on, including restore-CPSR-from-SPSR on writes.

Parameters:
- RESET_PC, 32'h0000_0000, value of r15 after reset
- RESET_CPSR, 32'h0000_00D3, CPSR after reset (SVC mode, I and F set)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- read_en  in  1  read request, sampled on posedge
- read_reg  in  4  register index to read
- read_value  out  32  registered read data
- write_en  in  1  write request, sampled on posedge
- write_reg  in  4  register index to write
- write_value  in  32  write data
- write_restore_from_SPSR  in  1  with write_en: also copy current-mode SPSR into CPSR
- pc_inc  in  1  fetch advance: r15 += 4
- cpsr_we  in  1  MSR-style CPSR write
- cpsr_wdata  in  32  CPSR write data
- spsr_we  in  1  write SPSR of current mode
- spsr_wdata  in  32  SPSR write data
- cpsr  out  32  current CPSR
- pc  out  32  current r15
- spsr_err  out  1  one-cycle pulse: SPSR access in USR/SYS mode

Behaviour:
- Reset (async, immediate): r0-r14 and all banks = 0; r15 = RESET_PC; CPSR = RESET_CPSR; all SPSRs = 0; read_value = 0; spsr_err = 0.
- Read timing:
  - read_en = 1 at edge N: read_value is updated at edge N with the content selected by read_reg, using the CPSR mode as it stood before edge N. The initiator can sample it from cycle N+1 onward (two-edge protocol: request, release, use).
  - read_value holds until the next read_en.
  - Reading r15 returns raw r15 with no +8 adjustment; initiators add their own offset.
- Write timing:
  - write_en = 1 at edge N: the register commits at edge N.
  - A read of the same register at the same edge returns the old value; there is no bypass.
  - A write held for several cycles rewrites each cycle, which is harmless.
- Bank selection from CPSR[4:0]:
  - USR 10000 and SYS 11111 share the user bank.
  - FIQ 10001, IRQ 10010, SVC 10011, ABT 10111 and UND 11011 each have a private r13/r14 and SPSR.
  - Any undefined mode value is treated as the user bank with no SPSR.
- write_restore_from_SPSR:
  - With write_en in an exception mode: CPSR <= SPSR(current mode) at the same edge as the register write. The register write goes to the pre-restore bank.
  - In USR/SYS/undefined mode: CPSR is unchanged, the register write still happens, and spsr_err pulses.
- spsr_we in USR/SYS/undefined mode: ignored, and spsr_err pulses.
- r15 priority at one edge: write_en to r15 > pc_inc. pc_inc adds 4 with modulo-2^32 wrap (32'hFFFF_FFFC -> 0).
- CPSR priority at one edge: restore_from_SPSR > cpsr_we.
- spsr_we together with restore in the same mode: the SPSR write lands after the restore reads the old SPSR value.
- Reset asserted mid-transaction: all pending effects are discarded and state returns to reset values.

Optional Feature:
- BANKED_FIQ_EN
  - Defined: FIQ mode also banks r8-r12; reads and writes of r8-r12 in FIQ use private copies (reset 0).
  - Undefined: r8-r12 are shared across all modes. FIQ still banks r13/r14/SPSR.

Test Plan:
- Reset: assert rst mid-cycle -> pc = 0, cpsr = 32'h0000_00D3, read_value = 0 immediately, without waiting for an edge.
- Read latency: write r3 = 32'hDEAD_BEEF; read_en/read_reg = 3 for one cycle -> read_value = DEADBEEF from the following cycle; it is still held two cycles later with read_en low.
- Branch-with-link sequence: pc = 32'h100; read r15 -> 32'h100; write r14 = 32'h104, then r15 = 32'h100 + 8 + 32'h40 -> pc = 32'h148, SVC r14 = 32'h104.
- Banking: in SVC write r13 = 32'h1000; cpsr_we to USR 32'h10; read r13 -> 0; cpsr_we back to SVC; read r13 -> 32'h1000.
- Restore: in IRQ, spsr_we = 32'h0000_0010; write r15 = 32'h200 with restore -> pc = 32'h200, cpsr = 32'h10. Repeat in USR -> cpsr unchanged, spsr_err pulses once.
- Collision: write_en r15 = 32'h80 with pc_inc at the same edge -> pc = 32'h80. Separately, pc_inc alone at pc = 32'hFFFF_FFFC -> pc = 0.
